// File: rtl/int_sequencer_if.sv
// int_sequencer_if -- signal bundle between the pipeline and the interrupt sequencer.
//
// Signals:
//   INT_in        external interrupt request
//   int_en        current INT flag (1 = interrupts enabled)
//   jmp_in_flight unresolved jump/branch in EX or MEM
//   mem_busy      data memory used this cycle by an older instruction
//   stall_if      freeze PC and IF/ID
//   flush_id      insert a bubble into ID/EX
//   push_pc       write the 32-bit PC to the stack
//   push_flags    write the flags word to the stack
//   load_vec      load PC from the interrupt vector
//   clr_int       clear the INT flag
//   state_out     current sequencer state, for debug
//
// Modports:
//   master  pipeline side (drives requests/status, receives commands)
//   slave   sequencer side
interface int_sequencer_if;
    logic       INT_in;
    logic       int_en;
    logic       jmp_in_flight;
    logic       mem_busy;
    logic       stall_if;
    logic       flush_id;
    logic       push_pc;
    logic       push_flags;
    logic       load_vec;
    logic       clr_int;
    logic [2:0] state_out;

    modport master (
        output INT_in, int_en, jmp_in_flight, mem_busy,
        input  stall_if, flush_id, push_pc, push_flags, load_vec, clr_int, state_out
    );

    modport slave (
        input  INT_in, int_en, jmp_in_flight, mem_busy,
        output stall_if, flush_id, push_pc, push_flags, load_vec, clr_int, state_out
    );
endinterface

// File: rtl/int_sequencer.sv
// int_sequencer -- interrupt entry sequencer for the pipeline.
//
// On an accepted interrupt the pipeline is stalled and flushed, in-flight
// instructions drain (at least 3 cycles, longer while a jump is unresolved),
// then PC and flags are pushed to the stack (each waiting for a free memory
// cycle), and finally the PC is loaded from the vector while INT is cleared.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    int_sequencer_if.slave (requests/status in, commands/debug out)
//
// Optional feature: define INT_PENDING_LATCH_EN to keep one interrupt request
// that arrives while busy or while interrupts are disabled, and serve it once
// the sequencer is idle with interrupts enabled.
module int_sequencer (
    input  logic             clk,
    input  logic             reset,
    int_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StDrain     = 3'd1,
        StPushPc    = 3'd2,
        StPushFlags = 3'd3,
        StLoadVec   = 3'd4
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] drain_cnt_q, drain_cnt_d;
    logic       req;
    logic       accept;

`ifdef INT_PENDING_LATCH_EN
    logic pending_q, pending_d;

    assign req = bus.INT_in | pending_q;
`else
    assign req = bus.INT_in;
`endif

    assign accept = req & bus.int_en;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            drain_cnt_q <= 2'd0;
`ifdef INT_PENDING_LATCH_EN
            pending_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
`ifdef INT_PENDING_LATCH_EN
            pending_q   <= pending_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d     = StDrain;
                    drain_cnt_d = 2'd2;
                end
            end
            StDrain: begin
                // Counter saturates at 0; exit only once no jump is unresolved.
                if (drain_cnt_q == 2'd0) begin
                    if (!bus.jmp_in_flight) begin
                        state_d = StPushPc;
                    end
                end else begin
                    drain_cnt_d = drain_cnt_q - 2'd1;
                end
            end
            StPushPc: begin
                if (!bus.mem_busy) begin
                    state_d = StPushFlags;
                end
            end
            StPushFlags: begin
                if (!bus.mem_busy) begin
                    state_d = StLoadVec;
                end
            end
            StLoadVec: begin
                state_d = StIdle;
            end
            default: begin
                // Unused encodings recover to idle.
                state_d     = StIdle;
                drain_cnt_d = 2'd0;
            end
        endcase
    end

`ifdef INT_PENDING_LATCH_EN
    // Single-entry pending latch: cleared when a sequence starts, set by a
    // request that cannot be accepted right now. Extra requests merge.
    always_comb begin
        pending_d = pending_q;
        if (state_q == StIdle && state_d == StDrain) begin
            pending_d = 1'b0;
        end else if (bus.INT_in && (state_q != StIdle || !bus.int_en)) begin
            pending_d = 1'b1;
        end
    end
`endif

    // Outputs: Moore decode of state; only the push commands see mem_busy.
    always_comb begin
        bus.stall_if   = 1'b0;
        bus.flush_id   = 1'b0;
        bus.push_pc    = 1'b0;
        bus.push_flags = 1'b0;
        bus.load_vec   = 1'b0;
        bus.clr_int    = 1'b0;
        case (state_q)
            StDrain: begin
                bus.stall_if = 1'b1;
                bus.flush_id = 1'b1;
            end
            StPushPc: begin
                bus.stall_if = 1'b1;
                bus.flush_id = 1'b1;
                bus.push_pc  = ~bus.mem_busy;
            end
            StPushFlags: begin
                bus.stall_if   = 1'b1;
                bus.flush_id   = 1'b1;
                bus.push_flags = ~bus.mem_busy;
            end
            StLoadVec: begin
                bus.stall_if = 1'b1;
                bus.flush_id = 1'b1;
                bus.load_vec = 1'b1;
                bus.clr_int  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.state_out = state_q;

endmodule
